// File: rtl/fwd_hazard_scoreboard_if.sv
// Purpose : ID-stage producer/consumer info in, EX forward selects and load-use stall out.
// Latency : none of its own; it only bundles the wires between the scoreboard and the pipeline.
// Backpr. : none; hz_stall is the hold request that the pipeline consumes.
// Ports   : master = pipeline side (drives ID info, ext_stall, flush); slave = scoreboard side.
interface fwd_hazard_scoreboard_if #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int CNTW      = 16
);
  localparam int SELW = $clog2(FWD_DEPTH + 1);

  logic                      ext_stall;
  logic                      flush;
  logic                      id_valid;
  logic                      id_reg_write;
  logic                      id_is_load;
  logic [REG_AW-1:0]         id_dest;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_use;
  logic                      hz_stall;
  logic                      ex_valid;
  logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
  logic [CNTW-1:0]           stall_cnt;

  modport master (
    output ext_stall, flush, id_valid, id_reg_write, id_is_load, id_dest, id_src_addr, id_src_use,
    input  hz_stall, ex_valid, ex_fwd_sel, stall_cnt
  );

  modport slave (
    input  ext_stall, flush, id_valid, id_reg_write, id_is_load, id_dest, id_src_addr, id_src_use,
    output hz_stall, ex_valid, ex_fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Purpose : forwarding-select and load-use hazard unit beside the ID/EX register.
// Latency : fwd selects and ex_valid are registered (1 cycle, aligned with EX); hz_stall is combinational.
// Backpr. : ext_stall freezes all state; hz_stall holds PC and IF/ID and bubbles EX.
// Ports   : clk, reset (async, active-high); bus (slave) carries ID info in and EX selects,
//           ex_valid, hz_stall and the saturating stall_cnt out.
module fwd_hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_REG  = 1,
  parameter int CNTW      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  fwd_hazard_scoreboard_if.slave  bus
);
  localparam int SELW = $clog2(FWD_DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [REG_AW-1:0] dest;
    logic              ld;
  } ent_t;

  // Only e[0..FWD_DEPTH-1] are kept: the last writeback stage is never compared
  // (the regfile writes before it is read), so its entry has no observable effect.
  ent_t [FWD_DEPTH-1:0]    sh_q, sh_d;
  logic                    ex_valid_q, ex_valid_d;
  logic [NUM_SRC*SELW-1:0] sel_q, sel_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;

  logic [NUM_SRC*SELW-1:0] next_sel;
  logic [NUM_SRC-1:0]      haz_src;
  logic                    hz;

  // Scan oldest to youngest so the youngest match (lowest k) is written last and wins.
  // A producer at e[k] will sit at e[k+1] once this consumer reaches EX, hence sel=k+1.
  always_comb begin
    next_sel = '0;
    haz_src  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (sh_q[k].vld && sh_q[k].wr && bus.id_src_use[i] &&
            (sh_q[k].dest == bus.id_src_addr[i*REG_AW +: REG_AW]) &&
            !((ZERO_REG != 0) && (sh_q[k].dest == '0))) begin
          next_sel[i*SELW +: SELW] = SELW'(k + 1);
          haz_src[i]               = sh_q[k].ld && (k < LOAD_LAT);
        end
      end
    end
    hz = (|haz_src) && bus.id_valid && !bus.flush;
  end

  always_comb begin
    sh_d       = sh_q;
    ex_valid_d = ex_valid_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    if (!bus.ext_stall) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        sh_d[k] = sh_q[k-1];
      end
      if (bus.flush || !bus.id_valid || hz) begin
        sh_d[0]    = '0;
        ex_valid_d = 1'b0;
        sel_d      = '0;
      end else begin
        sh_d[0]    = '{vld: 1'b1, wr: bus.id_reg_write, dest: bus.id_dest, ld: bus.id_is_load};
        ex_valid_d = 1'b1;
        sel_d      = next_sel;
      end
      if (hz && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q       <= '0;
      ex_valid_q <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
    end else begin
      sh_q       <= sh_d;
      ex_valid_q <= ex_valid_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.hz_stall   = hz;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_fwd_sel = sel_q;
  assign bus.stall_cnt  = cnt_q;
endmodule
